mux4_rr_tx: RTL and testbench
=============================

Name: mux4_rr_tx

Overview:
- Sequential 4-to-1 multiplexer: the transmit-side partner of the 1-to-4 demux.
- Collects words from four source channels (A, B, C, D) under valid/ready handshakes.
- Arbitrates round-robin and presents one registered word at a time on a single output (f, sel, f_valid) that can drive the demux's F/sel inputs directly.
- sel carries the source channel index, so the downstream demux routes each word back to the matching output lane (A=0, B=1, C=2, D=3).

Parameters:
- DATA_W, 1, width of each channel word and of f.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  4*DATA_W  channel words; channel i occupies bits [i*DATA_W +: DATA_W]; A=0, B=1, C=2, D=3.
- in_valid  input  4  per-channel word valid.
- in_ready  output  4  per-channel accept; combinational, one-hot or zero.
- f  output  DATA_W  multiplexed word, registered.
- sel  output  2  channel index of f, registered.
- f_valid  output  1  f/sel hold a word, registered.
- f_ready  input  1  downstream accepts the current word.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - f=0, sel=2'b00, f_valid=0.
  - Round-robin pointer ptr=2'd3, so the first search starts at channel A.
  - State IDLE.
- States:
  - IDLE: f_valid=0.
  - HOLD: f_valid=1.
- Grant (combinational):
  - Search in_valid starting at index ptr+1 (mod 4), in ascending wrap order.
  - The first set bit is the grant g; no valid bit means no grant.
- Load enable:
  - load_ok = (state==IDLE) | (state==HOLD & f_ready).
  - in_ready[g] = load_ok & grant exists; all other in_ready bits are 0.
  - in_ready never depends on in_data.
- Transfer on channel g (in_valid[g] & in_ready[g] at a rising edge):
  - f <= word g, sel <= g, ptr <= g, f_valid <= 1, state <= HOLD.
- Latency: exactly 1 clock from input acceptance to f_valid=1.
- HOLD & f_ready & no grant: f_valid <= 0, state <= IDLE. f and sel retain their last values.
- HOLD & !f_ready:
  - f, sel and f_valid are stable.
  - All in_ready bits are 0.
  - Sources may change in_valid freely.
- HOLD & f_ready & grant: back-to-back reload; sustained throughput is 1 word/clock.
- Fairness: with all four channels continuously valid and f_ready=1, sel sequence is 0,1,2,3,0,... A channel waits at most 3 other transfers.
- Simultaneous events:
  - A channel deasserting in_valid in the same cycle it would be granted is simply skipped.
  - ptr only advances on an actual transfer.
- Reset mid-operation: any held word is discarded; outputs take reset values immediately (asynchronously).
- f_ready while IDLE: ignored.
- ptr wrap: 3 -> 0 via 2-bit modular arithmetic.

Optional Feature:
- Macro MUX4_FIXED_PRIO_EN.
- Defined:
  - Grant is fixed priority A > B > C > D (lowest index wins).
  - ptr is not used; sel still reports the channel.
  - Starvation of lower channels is permitted.
- Undefined (default): round-robin as described above.
- Ports, latency and handshakes are identical in both builds.

Test Plan:
- Reset mid-stream:
  - Stimulus: rst_n=0 asserted while f_valid=1, sel=2.
  - Required: f=0, sel=0, f_valid=0 immediately, with no clock needed.
  - After release, with in_valid=4'b1111, the first sel=0.
- Single word (DATA_W=8):
  - Stimulus: in_valid=4'b0100, channel C data 8'hA5, f_ready=1.
  - Required: in_ready=4'b0100 in the same cycle.
  - Next clock: f=8'hA5, sel=2, f_valid=1.
  - Following clock: f_valid=0, f still 8'hA5.
- Round robin:
  - Stimulus: in_valid=4'b1111 held, data A..D = 11,22,33,44, f_ready=1.
  - Required: sel 0,1,2,3,0 and f 11,22,33,44,11 on consecutive clocks; f_valid stays 1.
- Backpressure:
  - Stimulus: f_ready=0 for 3 clocks while f_valid=1, sel=1, in_valid=4'b1111.
  - Required: in_ready=0, and f/sel unchanged throughout.
  - On the f_ready=1 cycle: in_ready=4'b0100; next clock sel=2.
- Skip a dropped channel:
  - Stimulus: ptr=0, in_valid=4'b1010.
  - Required: grant B (sel=1), then D (sel=3), then B again.
  - Under MUX4_FIXED_PRIO_EN the same stimulus gives sel 1,1,1 (B always wins).
- Pairing with the demux:
  - Connect f/sel to the existing demux F/sel (DATA_W=1).
  - Required: each accepted channel bit appears on the matching A–D output exactly one clock after acceptance.

Source files
------------

// File: rtl/mux4_rr_tx.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_tx
// Description : Sequential 4-to-1 transmit multiplexer. Collects words from
//               four valid/ready source channels (A=0, B=1, C=2, D=3),
//               arbitrates between them and presents one registered word at
//               a time on f/sel/f_valid. The f/sel pair can drive the F/sel
//               inputs of the partner 1-to-4 demux directly, because sel
//               carries the index of the source channel.
//
// Ports       : clk       - system clock, rising edge
//               rst_n     - asynchronous active-low reset
//               in_data   - channel words, channel i at [i*DATA_W +: DATA_W]
//               in_valid  - per-channel word valid
//               in_ready  - per-channel accept (combinational, one-hot/zero)
//               f         - multiplexed word (registered)
//               sel       - channel index of f (registered)
//               f_valid   - f/sel hold a word (registered)
//               f_ready   - downstream accepts the current word
//
// Build macro : MUX4_FIXED_PRIO_EN
//               undefined - round-robin arbitration (default)
//               defined   - fixed priority A > B > C > D
//
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_rr_tx #(
    parameter int DATA_W = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DATA_W-1:0]   in_data,
    input  logic [3:0]            in_valid,
    output logic [3:0]            in_ready,
    output logic [DATA_W-1:0]     f,
    output logic [1:0]            sel,
    output logic                  f_valid,
    input  logic                  f_ready
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]        r_state;
    logic [DATA_W-1:0] r_f;
    logic [1:0]        r_sel;

    logic              w_grant_vld;
    logic [1:0]        w_grant;
    logic              w_load_ok;
    logic              w_xfer;
    logic [DATA_W-1:0] w_word;

`ifdef MUX4_FIXED_PRIO_EN
    // Fixed priority: scanning from D down to A lets the lowest valid index
    // overwrite any higher one, so A wins whenever it is valid.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (in_valid[i]) begin
                w_grant_vld = 1'b1;
                w_grant     = i[1:0];
            end
        end
    end
`else
    // Round-robin pointer: index of the last channel that transferred.
    // Reset to 3 so that the very first search starts at channel A.
    logic [1:0] r_ptr;

    // Search order is ptr+1, ptr+2, ptr+3, ptr (mod 4). Scanning offsets from
    // the farthest (4 == ptr itself) to the nearest (1) means the nearest
    // valid channel is the last assignment and therefore wins.
    always_comb begin
        logic [1:0] v_idx;
        w_grant_vld = 1'b0;
        w_grant     = 2'd0;
        v_idx       = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            v_idx = r_ptr + k[1:0];
            if (in_valid[v_idx]) begin
                w_grant_vld = 1'b1;
                w_grant     = v_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 2'd3;
        end else if (w_xfer) begin
            r_ptr <= w_grant;
        end
    end
`endif

    // A new word may be loaded when the output register is empty, or when
    // its current word is leaving this cycle.
    assign w_load_ok = (r_state == S_IDLE) | ((r_state == S_HOLD) & f_ready);
    assign w_xfer    = w_load_ok & w_grant_vld;

    // Ready is derived only from state, f_ready and in_valid, never from data,
    // and is asserted only on the granted channel (whose valid is set).
    always_comb begin
        in_ready = 4'b0000;
        if (w_xfer) begin
            in_ready[w_grant] = 1'b1;
        end
    end

    always_comb begin
        w_word = '0;
        for (int i = 0; i < 4; i++) begin
            if (w_grant == i[1:0]) begin
                w_word = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_f     <= '0;
            r_sel   <= 2'b00;
        end else if (w_xfer) begin
            r_state <= S_HOLD;
            r_f     <= w_word;
            r_sel   <= w_grant;
        end else if ((r_state == S_HOLD) && f_ready) begin
            // Word consumed with nothing to replace it; f/sel keep last value.
            r_state <= S_IDLE;
        end
    end

    assign f       = r_f;
    assign sel     = r_sel;
    assign f_valid = (r_state == S_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4_rr_tx
// Description : Directed, table-driven self-checking bench for mux4_rr_tx
//               (DATA_W=8, default round-robin build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_tx;

    localparam int DATA_W = 8;

    logic                clk;
    logic                rst_n;
    logic [4*DATA_W-1:0] in_data;
    logic [3:0]          in_valid;
    logic [3:0]          in_ready;
    logic [DATA_W-1:0]   f;
    logic [1:0]          sel;
    logic                f_valid;
    logic                f_ready;

    int total;
    int bad;

    mux4_rr_tx #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .f        (f),
        .sel      (sel),
        .f_valid  (f_valid),
        .f_ready  (f_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic        fr;
        logic [3:0]  exp_ready;   // checked before the edge
        logic [7:0]  exp_f;       // checked after the edge
        logic [1:0]  exp_sel;
        logic        exp_fv;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] v, input logic [31:0] d, input logic fr,
                       input logic [3:0] ir, input logic [7:0] ef,
                       input logic [1:0] es, input logic efv);
        vec_t t;
        t.valid = v; t.data = d; t.fr = fr;
        t.exp_ready = ir; t.exp_f = ef; t.exp_sel = es; t.exp_fv = efv;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n    = 1'b0;
        in_data  = '0;
        in_valid = 4'b0000;
        f_ready  = 1'b0;

        // Round robin from reset (ptr=3, so A first), wrap 3 -> 0
        add(4'b1111, 32'h44332211, 1'b1, 4'b0001, 8'h11, 2'd0, 1'b1);
        add(4'b1111, 32'h44332211, 1'b1, 4'b0010, 8'h22, 2'd1, 1'b1);
        add(4'b1111, 32'h44332211, 1'b1, 4'b0100, 8'h33, 2'd2, 1'b1);
        add(4'b1111, 32'h44332211, 1'b1, 4'b1000, 8'h44, 2'd3, 1'b1);
        add(4'b1111, 32'h44332211, 1'b1, 4'b0001, 8'h11, 2'd0, 1'b1);
        add(4'b1111, 32'h44332211, 1'b1, 4'b0010, 8'h22, 2'd1, 1'b1);
        // Backpressure: 3 stalled clocks holding sel=1, then release
        add(4'b1111, 32'h44332211, 1'b0, 4'b0000, 8'h22, 2'd1, 1'b1);
        add(4'b1111, 32'h44332211, 1'b0, 4'b0000, 8'h22, 2'd1, 1'b1);
        add(4'b1111, 32'h44332211, 1'b0, 4'b0000, 8'h22, 2'd1, 1'b1);
        add(4'b1111, 32'h44332211, 1'b1, 4'b0100, 8'h33, 2'd2, 1'b1);
        // Put ptr at 0, then skip the dropped channels A and C
        add(4'b0001, 32'hDDCCBBAA, 1'b1, 4'b0001, 8'hAA, 2'd0, 1'b1);
        add(4'b1010, 32'hDDCCBBAA, 1'b1, 4'b0010, 8'hBB, 2'd1, 1'b1);
        add(4'b1010, 32'hDDCCBBAA, 1'b1, 4'b1000, 8'hDD, 2'd3, 1'b1);
        add(4'b1010, 32'hDDCCBBAA, 1'b1, 4'b0010, 8'hBB, 2'd1, 1'b1);
        // Single word on C, then drain to IDLE with f/sel retained
        add(4'b0100, 32'h00A50000, 1'b1, 4'b0100, 8'hA5, 2'd2, 1'b1);
        add(4'b0000, 32'h00A50000, 1'b1, 4'b0000, 8'hA5, 2'd2, 1'b0);
        // f_ready ignored in IDLE: stays idle, and still loads when f_ready=0
        add(4'b0000, 32'h00000000, 1'b0, 4'b0000, 8'hA5, 2'd2, 1'b0);
        add(4'b0001, 32'h00000077, 1'b0, 4'b0001, 8'h77, 2'd0, 1'b1);
        // Stalled word with no new requests, then reach sel=2 for the reset test
        add(4'b0000, 32'h00000000, 1'b0, 4'b0000, 8'h77, 2'd0, 1'b1);
        add(4'b0100, 32'h00990000, 1'b1, 4'b0100, 8'h99, 2'd2, 1'b1);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_f", 32'(f), 32'h0);
        chk("reset_sel", 32'(sel), 32'h0);
        chk("reset_fvalid", 32'(f_valid), 32'h0);
        chk("reset_ready", 32'(in_ready), 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            in_valid = vecs[i].valid;
            in_data  = vecs[i].data;
            f_ready  = vecs[i].fr;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_f", i), 32'(f), 32'(vecs[i].exp_f));
            chk($sformatf("v%0d_sel", i), 32'(sel), 32'(vecs[i].exp_sel));
            chk($sformatf("v%0d_f_valid", i), 32'(f_valid), 32'(vecs[i].exp_fv));
        end

        // Reset mid-stream: outputs clear without any clock edge
        in_valid = 4'b0000;
        f_ready  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_f", 32'(f), 32'h0);
        chk("async_rst_sel", 32'(sel), 32'h0);
        chk("async_rst_fvalid", 32'(f_valid), 32'h0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 4'b1111;
        in_data  = 32'h44332211;
        f_ready  = 1'b1;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("post_rst_sel", 32'(sel), 32'h0);
        chk("post_rst_f", 32'(f), 32'h11);
        chk("post_rst_fvalid", 32'(f_valid), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
